ysyx_25040129_operand_stage: RTL and testbench

- Parametrised successor to the decode-side operand resolver.
- Resolves rs1/rs2 against N forwarding channels. Youngest matching stage wins.
- Raises a RAW stall only when the youngest match cannot yet supply data.
- Registers resolved operands into a valid/ready pipeline slot toward EXU, with flush support and a saturating hazard-stall counter.

---
 rtl/ysyx_25040129_operand_stage_if.sv | 43 ++++
 rtl/ysyx_25040129_operand_stage.sv | 116 +++++++++++
 tb/tb_ysyx_25040129_operand_stage.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040129_operand_stage_if.sv
// Decode-to-EXU operand bundle: decoded sources, forwarding channels and the
// valid/ready slot toward EXU.
interface ysyx_25040129_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [REG_AW-1:0]         rs1_id;
    logic [REG_AW-1:0]         rs2_id;
    logic                      use_rs1;
    logic                      use_rs2;
    logic [XLEN-1:0]           rf_rs1_data;
    logic [XLEN-1:0]           rf_rs2_data;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD-1:0]        fwd_wen;
    logic [NUM_FWD-1:0]        fwd_dvalid;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           out_rs1_data;
    logic [XLEN-1:0]           out_rs2_data;
    logic [CNT_W-1:0]          stall_cnt;

    modport slave (
        input  in_valid, rs1_id, rs2_id, use_rs1, use_rs2,
        input  rf_rs1_data, rf_rs2_data,
        input  fwd_rd, fwd_wen, fwd_dvalid, fwd_data,
        input  flush, out_ready,
        output in_ready, out_valid, out_rs1_data, out_rs2_data, stall_cnt
    );

    modport master (
        output in_valid, rs1_id, rs2_id, use_rs1, use_rs2,
        output rf_rs1_data, rf_rs2_data,
        output fwd_rd, fwd_wen, fwd_dvalid, fwd_data,
        output flush, out_ready,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data, stall_cnt
    );
endinterface

// File: rtl/ysyx_25040129_operand_stage.sv
// Operand stage: resolves rs1/rs2 through N forwarding channels (youngest
// wins), stalls on not-yet-ready data, and registers operands toward EXU.
module ysyx_25040129_operand_stage #(
    parameter int XLEN    = 32,
    parameter int REG_AW  = 4,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_25040129_operand_stage_if.slave  bus
);

    // Returns {stall, value}. stall is set only when the youngest writer of
    // the source exists but has not produced its data yet.
    function automatic logic [XLEN:0] resolve_src(
        input logic [REG_AW-1:0]         rs,
        input logic                      use_src,
        input logic [XLEN-1:0]           rf_data,
        input logic [NUM_FWD*REG_AW-1:0] rd,
        input logic [NUM_FWD-1:0]        wen,
        input logic [NUM_FWD-1:0]        dvalid,
        input logic [NUM_FWD*XLEN-1:0]   data
    );
        logic            hit;
        logic            stall;
        logic [XLEN-1:0] val;
        hit   = 1'b0;
        stall = 1'b0;
        val   = rf_data;
        if (!use_src) begin
            val = rf_data;
        end else if (rs == {REG_AW{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else begin
            for (int i = 0; i < NUM_FWD; i++) begin
                if (!hit && wen[i] && (rd[i*REG_AW +: REG_AW] == rs)) begin
                    hit   = 1'b1;
                    stall = !dvalid[i];
                    val   = data[i*XLEN +: XLEN];
                end
            end
        end
        return {stall, val};
    endfunction

    logic [XLEN:0]    src1_s;
    logic [XLEN:0]    src2_s;
    logic             hazard_s;
    logic             in_ready_s;
    logic             fire_s;
    logic             stall_inc_s;
    logic             out_valid_r;
    logic [XLEN-1:0]  out_rs1_r;
    logic [XLEN-1:0]  out_rs2_r;
    logic [CNT_W-1:0] stall_cnt_r;

    // Operand resolution, hazard detection and handshake qualification.
    always_comb begin
        src1_s      = resolve_src(bus.rs1_id, bus.use_rs1, bus.rf_rs1_data,
                                  bus.fwd_rd, bus.fwd_wen, bus.fwd_dvalid, bus.fwd_data);
        src2_s      = resolve_src(bus.rs2_id, bus.use_rs2, bus.rf_rs2_data,
                                  bus.fwd_rd, bus.fwd_wen, bus.fwd_dvalid, bus.fwd_data);
        hazard_s    = src1_s[XLEN] | src2_s[XLEN];
        in_ready_s  = !hazard_s && (!out_valid_r || bus.out_ready) && !bus.flush;
        fire_s      = bus.in_valid && in_ready_s;
        stall_inc_s = bus.in_valid && hazard_s && !bus.flush;
    end

    // Output slot occupancy; flush empties the slot ahead of any fire/drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r <= 1'b0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Operand registers load only on fire, so a held slot stays stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_rs1_r <= {XLEN{1'b0}};
            out_rs2_r <= {XLEN{1'b0}};
        end else if (fire_s) begin
            out_rs1_r <= src1_s[XLEN-1:0];
            out_rs2_r <= src2_s[XLEN-1:0];
        end else begin
            out_rs1_r <= out_rs1_r;
            out_rs2_r <= out_rs2_r;
        end
    end

    // Saturating RAW-stall cycle counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_rs1_data = out_rs1_r;
    assign bus.out_rs2_data = out_rs2_r;
    assign bus.stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_ysyx_25040129_operand_stage.sv
// Bench for the operand stage: a behavioural model checked every cycle plus
// directed vectors with literal expectations; a CNT_W=2 twin checks saturation.
module tb_ysyx_25040129_operand_stage;

    logic clock;
    logic reset;

    ysyx_25040129_operand_stage_if #(.XLEN(32), .REG_AW(4), .NUM_FWD(3), .CNT_W(16)) bus ();
    ysyx_25040129_operand_stage_if #(.XLEN(32), .REG_AW(4), .NUM_FWD(3), .CNT_W(2))  bus2 ();

    ysyx_25040129_operand_stage #(.XLEN(32), .REG_AW(4), .NUM_FWD(3), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    ysyx_25040129_operand_stage #(.XLEN(32), .REG_AW(4), .NUM_FWD(3), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2)
    );

    // Forwarding channels as plain arrays; channel i lands at bits [i*W +: W].
    logic [3:0]  f_rd  [3];
    logic        f_wen [3];
    logic        f_dv  [3];
    logic [31:0] f_dat [3];

    assign bus.fwd_rd     = {f_rd[2], f_rd[1], f_rd[0]};
    assign bus.fwd_wen    = {f_wen[2], f_wen[1], f_wen[0]};
    assign bus.fwd_dvalid = {f_dv[2], f_dv[1], f_dv[0]};
    assign bus.fwd_data   = {f_dat[2], f_dat[1], f_dat[0]};

    assign bus2.in_valid    = bus.in_valid;
    assign bus2.rs1_id      = bus.rs1_id;
    assign bus2.rs2_id      = bus.rs2_id;
    assign bus2.use_rs1     = bus.use_rs1;
    assign bus2.use_rs2     = bus.use_rs2;
    assign bus2.rf_rs1_data = bus.rf_rs1_data;
    assign bus2.rf_rs2_data = bus.rf_rs2_data;
    assign bus2.fwd_rd      = bus.fwd_rd;
    assign bus2.fwd_wen     = bus.fwd_wen;
    assign bus2.fwd_dvalid  = bus.fwd_dvalid;
    assign bus2.fwd_data    = bus.fwd_data;
    assign bus2.flush       = bus.flush;
    assign bus2.out_ready   = bus.out_ready;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model state: what the slot and counters must hold after the last edge.
    bit          m_known = 1'b0;
    bit          m_rst_seen = 1'b0;
    bit          m_valid;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    int          m_cnt;
    int          m_cnt2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Finds the youngest channel writing rs; stalls only if that one lacks data.
    task automatic m_resolve(input logic [3:0] rs, input logic use_src, input logic [31:0] rf,
                             output bit haz, output logic [31:0] val);
        int y;
        haz = 1'b0;
        val = rf;
        y   = -1;
        if (use_src && rs != 4'd0) begin
            for (int i = 0; i < 3; i++)
                if (y < 0 && f_wen[i] && f_rd[i] == rs) y = i;
            if (y >= 0) begin
                if (f_dv[y]) val = f_dat[y];
                else haz = 1'b1;
            end
        end else if (use_src) begin
            val = 32'd0;
        end
    endtask

    // One clock: compare DUT against the model at negedge, advance the model,
    // then return just after the following posedge.
    task automatic step();
        bit          h1, h2, hz, rdy, fire;
        logic [31:0] v1, v2;
        @(negedge clock);
        m_resolve(bus.rs1_id, bus.use_rs1, bus.rf_rs1_data, h1, v1);
        m_resolve(bus.rs2_id, bus.use_rs2, bus.rf_rs2_data, h2, v2);
        hz   = h1 | h2;
        rdy  = !hz && (!m_valid || bus.out_ready) && !bus.flush;
        fire = bus.in_valid && rdy;
        if (m_known) begin
            check("mdl_in_ready", 32'(bus.in_ready), 32'(rdy));
            check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid || m_rst_seen) begin
                check("mdl_rs1", bus.out_rs1_data, m_rs1);
                check("mdl_rs2", bus.out_rs2_data, m_rs2);
            end
            check("mdl_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
            check("mdl_cnt2", 32'(bus2.stall_cnt), 32'(m_cnt2));
        end
        if (reset) begin
            m_known = 1'b1; m_rst_seen = 1'b1; m_valid = 1'b0;
            m_rs1 = 32'd0; m_rs2 = 32'd0; m_cnt = 0; m_cnt2 = 0;
        end else if (m_known) begin
            if (bus.in_valid && hz && !bus.flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (bus.flush) m_valid = 1'b0;
            else if (fire) begin
                m_valid = 1'b1; m_rs1 = v1; m_rs2 = v2; m_rst_seen = 1'b0;
            end else if (bus.out_ready) m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clr_fwd();
        for (int i = 0; i < 3; i++) begin
            f_rd[i] = 4'd0; f_wen[i] = 1'b0; f_dv[i] = 1'b0; f_dat[i] = 32'd0;
        end
    endtask

    task automatic set_src(input logic [3:0] r1, input logic [3:0] r2,
                           input logic [31:0] d1, input logic [31:0] d2);
        bus.rs1_id = r1; bus.rs2_id = r2;
        bus.rf_rs1_data = d1; bus.rf_rs2_data = d2;
        bus.use_rs1 = 1'b1; bus.use_rs2 = 1'b1;
    endtask

    initial begin
        int exp_small [6];
        exp_small = '{1, 2, 3, 3, 3, 3};
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        set_src(4'd0, 4'd0, 32'd0, 32'd0);
        clr_fwd();
        step();
        step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rs1", bus.out_rs1_data, 32'd0);
        check("rst_cnt", 32'(bus.stall_cnt), 32'd0);
        reset = 1'b0;

        // Plain register-file operands, back to back.
        bus.in_valid = 1'b1;
        set_src(4'd5, 4'd6, 32'h11, 32'h22);
        #1 check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_rs1", bus.out_rs1_data, 32'h11);
        check("t1_rs2", bus.out_rs2_data, 32'h22);
        set_src(4'd5, 4'd6, 32'h33, 32'h44);
        step();
        check("t1b_rs1", bus.out_rs1_data, 32'h33);
        check("t1b_valid", 32'(bus.out_valid), 32'd1);

        // Youngest channel wins.
        set_src(4'd3, 4'd6, 32'h1, 32'h22);
        f_rd[0] = 4'd3; f_wen[0] = 1'b1; f_dv[0] = 1'b1; f_dat[0] = 32'hAAAA;
        f_rd[2] = 4'd3; f_wen[2] = 1'b1; f_dv[2] = 1'b1; f_dat[2] = 32'hBBBB;
        step();
        check("t2_rs1", bus.out_rs1_data, 32'hAAAA);

        // Young match not ready blocks even though an older one is.
        clr_fwd();
        set_src(4'd5, 4'd7, 32'h11, 32'h2);
        f_rd[0] = 4'd7; f_wen[0] = 1'b1; f_dv[0] = 1'b0; f_dat[0] = 32'h0;
        f_rd[1] = 4'd7; f_wen[1] = 1'b1; f_dv[1] = 1'b1; f_dat[1] = 32'h99;
        #1 check("t3_in_ready", 32'(bus.in_ready), 32'd0);
        step(); step(); step();
        check("t3_cnt", 32'(bus.stall_cnt), 32'd3);
        check("t3_valid", 32'(bus.out_valid), 32'd0);
        f_dv[0] = 1'b1; f_dat[0] = 32'h55;
        step();
        check("t3_rs2", bus.out_rs2_data, 32'h55);
        check("t3_valid2", 32'(bus.out_valid), 32'd1);

        // x0 never forwards and never stalls.
        clr_fwd();
        set_src(4'd0, 4'd6, 32'h1234, 32'h22);
        f_rd[0] = 4'd0; f_wen[0] = 1'b1; f_dv[0] = 1'b0; f_dat[0] = 32'hFF;
        step();
        check("t4_rs1", bus.out_rs1_data, 32'h0);
        check("t4_cnt", 32'(bus.stall_cnt), 32'd3);

        // Held slot, then flush while downstream becomes ready.
        clr_fwd();
        bus.out_ready = 1'b0;
        set_src(4'd5, 4'd6, 32'h77, 32'h88);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            check("t5_hold_rs2", bus.out_rs2_data, 32'h22);
            check("t5_hold_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.flush = 1'b1; bus.out_ready = 1'b1;
        #1 check("t5_flush_ready", 32'(bus.in_ready), 32'd0);
        step();
        check("t5_flush_valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        step();

        // Counter saturation on the CNT_W=2 twin, flush suppression, reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        check("t6_rst_cnt2", 32'(bus2.stall_cnt), 32'd0);
        bus.in_valid = 1'b1;
        set_src(4'd3, 4'd6, 32'h1, 32'h2);
        f_rd[0] = 4'd3; f_wen[0] = 1'b1; f_dv[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t6_cnt2", 32'(bus2.stall_cnt), 32'(exp_small[k]));
            check("t6_cnt", 32'(bus.stall_cnt), 32'(k + 1));
        end
        bus.flush = 1'b1;
        step();
        check("t6_flush_cnt", 32'(bus.stall_cnt), 32'd6);
        bus.flush = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst2_cnt", 32'(bus.stall_cnt), 32'd0);
        check("t6_rst2_cnt2", 32'(bus2.stall_cnt), 32'd0);
        check("t6_rst2_valid", 32'(bus.out_valid), 32'd0);

        // Unused source passes rf data and never stalls.
        clr_fwd();
        set_src(4'd5, 4'd7, 32'h11, 32'hCAFE);
        bus.use_rs2 = 1'b0;
        f_rd[0] = 4'd7; f_wen[0] = 1'b1; f_dv[0] = 1'b0; f_dat[0] = 32'hDEAD;
        step();
        check("t7_valid", 32'(bus.out_valid), 32'd1);
        check("t7_rs2", bus.out_rs2_data, 32'hCAFE);
        check("t7_cnt", 32'(bus.stall_cnt), 32'd0);
        bus.in_valid = 1'b0;
        step();
        check("t7_drain", 32'(bus.out_valid), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
